// File: rtl/aes_pkg.sv
// Shared AES types, round-count constants and GF(2^8) helpers for the inverse-cipher datapath.
// Holds no state; everything here is pure combinational definition.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } inv_fsm_t;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    localparam byte_t INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (InvMixColumns only needs 09/0b/0d/0e).
    function automatic byte_t gf_mul(input byte_t a, input logic [3:0] k);
        byte_t x2;
        byte_t x4;
        byte_t x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES decryption round: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
// Purely combinational; i_last skips InvMixColumns for the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t i_state,
    input  state_t i_rk,
    input  logic   i_last,
    output state_t o_next_state
);

    // Byte k of the block sits at [127-8k -: 8]; row r, column c is byte r+4c.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8*k -: 8] = INV_SBOX[s[127 - 8*k -: 8]];
        end
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        byte_t  a0;
        byte_t  a1;
        byte_t  a2;
        byte_t  a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
            o[119 - 32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
            o[111 - 32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
            o[103 - 32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
        end
        return o;
    endfunction

    state_t w_shifted;
    state_t w_subbed;
    state_t w_keyed;

    assign w_shifted    = inv_shift_rows(i_state);
    assign w_subbed     = inv_sub_bytes(w_shifted);
    assign w_keyed      = w_subbed ^ i_rk;
    assign o_next_state = i_last ? w_keyed : inv_mix_columns(w_keyed);

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse cipher: one round per clock, plaintext valid NR cycles after acceptance.
// Holds out_data until out_ready; accepts a new block only from IDLE (one block per NR+2 cycles).
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter  int NR = NR_128,
    localparam int RW = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    output logic [RW-1:0] rk_idx,
    input  logic [127:0]  rk_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy
);

    inv_fsm_t      r_fsm;
    inv_fsm_t      w_fsm_nxt;
    logic [RW-1:0] r_cnt;
    logic [RW-1:0] w_cnt_nxt;
    state_t        r_state;
    state_t        w_state_nxt;
    state_t        w_round_out;
    logic          w_last;

    assign w_last   = (r_cnt == '0);
    assign out_data = r_state;

    aes_inv_round u_round (
        .i_state      (r_state),
        .i_rk         (rk_data),
        .i_last       (w_last),
        .o_next_state (w_round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_cnt   <= '0;
            r_state <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs depend only on FSM/cnt (and rst), never on in_valid.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        rk_idx      = '0;
        case (r_fsm)
            IDLE: begin
                in_ready = !rst;
                rk_idx   = RW'(NR);
                if (in_valid && !rst) begin
                    w_state_nxt = in_data ^ rk_data;
                    w_cnt_nxt   = RW'(NR - 1);
                    w_fsm_nxt   = ROUND;
                end
            end
            ROUND: begin
                busy        = !rst;
                rk_idx      = r_cnt;
                w_state_nxt = w_round_out;
                if (w_last) begin
                    w_fsm_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - RW'(1);
                end
            end
            DONE: begin
                busy      = !rst;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_fsm_nxt = IDLE;
                end
            end
            default: begin
                w_fsm_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl: FIPS-197 C.1 (NR=10) and C.3 (NR=14) vectors,
// backpressure, back-to-back, mid-round reset and input-while-busy scenarios.
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_aes_inv_cipher_ctrl;

    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] JUNK = 128'hdeadbeef0badf00dcafebabe12345678;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_data, a_rk_data, a_out_data;
    logic [3:0]   a_rk_idx;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_data, b_rk_data, b_out_data;
    logic [3:0]   b_rk_idx;

    logic [127:0] ks_a [0:15];
    logic [127:0] ks_b [0:15];
    logic [31:0]  w [0:59];
    logic         rk_junk;

    assign a_rk_data = rk_junk ? JUNK : ks_a[a_rk_idx];
    assign b_rk_data = ks_b[b_rk_idx];

    aes_inv_cipher_ctrl #(.NR(10)) u_dut10 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .rk_idx(a_rk_idx), .rk_data(a_rk_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .busy(a_busy)
    );

    aes_inv_cipher_ctrl #(.NR(14)) u_dut14 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .rk_idx(b_rk_idx), .rk_data(b_rk_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .busy(b_busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    task automatic key_expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_wait(input string tag, input int n, input int limit);
        checks++;
        if (n >= limit) begin
            errors++;
            $error("FAIL %s: wait expired after %0d cycles", tag, n);
        end
    endtask

    task automatic chk_rst_state(input string tag);
        checks++;
        if (a_in_ready !== 1'b0 || a_busy !== 1'b0 || a_out_valid !== 1'b0 ||
            b_in_ready !== 1'b0 || b_busy !== 1'b0 || b_out_valid !== 1'b0) begin
            errors++;
            $error("FAIL %s: in_ready=%b/%b busy=%b/%b out_valid=%b/%b during reset",
                   tag, a_in_ready, b_in_ready, a_busy, b_busy, a_out_valid, b_out_valid);
        end
    endtask

    task automatic run_a(input logic [127:0] ct, output logic [127:0] pt, output int lat);
        int k;
        a_in_data  = ct;
        a_in_valid = 1'b1;
        k = 0;
        while (!a_in_ready && k < 50) begin tick; k++; end
        chk_wait("run_a_accept_wait", k, 50);
        tick;
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 50) begin tick; lat++; end
        chk_wait("run_a_out_wait", lat, 50);
        pt = a_out_data;
    endtask

    logic [127:0] pt;
    int           lat, acc1, acc2, rdy_in_round, ov_seen, k;

    initial begin
        rst = 1'b1;
        rk_junk = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        for (int r = 0; r < 16; r++) begin ks_a[r] = '0; ks_b[r] = '0; end
        key_expand({K128, 128'h0}, 4, 10);
        for (int r = 0; r <= 10; r++) ks_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        key_expand(K256, 8, 14);
        for (int r = 0; r <= 14; r++) ks_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        // Reset state
        tick; tick;
        chk_rst_state("rst_state");
        `CHK("rst_in_ready", a_in_ready, 1'b0)
        `CHK("rst_busy", a_busy, 1'b0)
        `CHK("rst_out_valid", a_out_valid, 1'b0)
        `CHK("rst_out_data", a_out_data, 128'h0)
        `CHK("rst_rk_idx10", a_rk_idx, 4'd10)
        `CHK("rst_rk_idx14", b_rk_idx, 4'd14)
        `CHK("rst_busy14", b_busy, 1'b0)
        rst = 1'b0;
        tick;
        `CHK("post_rst_in_ready", a_in_ready, 1'b1)
        `CHK("post_rst_in_ready14", b_in_ready, 1'b1)

        // C.1 with out_ready low: latency, key index sequence, then hold under backpressure
        a_in_data  = CT1;
        a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        for (int r = 9; r >= 0; r--) begin
            `CHK("c1_rk_idx", a_rk_idx, 4'(r))
            `CHK("c1_in_ready_round", a_in_ready, 1'b0)
            `CHK("c1_out_valid_early", a_out_valid, 1'b0)
            tick;
        end
        `CHK("c1_out_valid", a_out_valid, 1'b1)
        `CHK("c1_plaintext", a_out_data, PT)
        `CHK("c1_rk_idx_done", a_rk_idx, 4'd0)
        for (int i = 0; i < 5; i++) begin
            tick;
            `CHK("bp_out_valid", a_out_valid, 1'b1)
            `CHK("bp_out_data", a_out_data, PT)
        end
        a_out_ready = 1'b1;
        tick;
        `CHK("bp_release_in_ready", a_in_ready, 1'b1)
        `CHK("bp_release_out_valid", a_out_valid, 1'b0)
        `CHK("bp_release_busy", a_busy, 1'b0)

        // Key bus noise while idle must not start anything
        rk_junk = 1'b1;
        tick; tick;
        `CHK("idle_rk_noise_busy", a_busy, 1'b0)
        `CHK("idle_rk_noise_in_ready", a_in_ready, 1'b1)
        rk_junk = 1'b0;

        // Back-to-back with in_valid held high (out_ready already high)
        a_in_data = CT1;
        a_in_valid = 1'b1;
        acc1 = -1; acc2 = -1; rdy_in_round = 0; pt = '0;
        for (int i = 0; i < 40 && acc2 < 0; i++) begin
            if (a_in_ready) begin
                if (acc1 < 0) acc1 = cyc + 1;
                else          acc2 = cyc + 1;
            end
            if (a_busy && !a_out_valid && a_in_ready) rdy_in_round++;
            if (a_out_valid) pt = a_out_data;
            tick;
            if (acc1 >= 0) a_in_data = CT1 ^ 128'hff;
        end
        a_in_valid = 1'b0;
        `CHK("b2b_second_accepted", (acc2 >= 0), 1'b1)
        `CHK("b2b_accept_spacing", acc2 - acc1, 12)
        `CHK("b2b_first_plaintext", pt, PT)
        `CHK("b2b_in_ready_in_round", rdy_in_round, 0)
        k = 0;
        while (!a_out_valid && k < 50) begin tick; k++; end
        chk_wait("b2b_blk2_wait", k, 50);
        `CHK("b2b_blk2_latency", k, 10)
        `CHK("b2b_blk2_differs", (a_out_data !== PT), 1'b1)
        tick;

        // Input pulse while busy is ignored
        a_in_data = CT1;
        a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        tick; tick; tick;
        a_in_data = JUNK;
        a_in_valid = 1'b1;
        `CHK("busy_in_ready", a_in_ready, 1'b0)
        tick;
        a_in_valid = 1'b0;
        lat = 4;
        while (!a_out_valid && lat < 50) begin tick; lat++; end
        chk_wait("busy_wait", lat, 50);
        `CHK("busy_latency", lat, 10)
        `CHK("busy_plaintext", a_out_data, PT)
        tick; tick;
        `CHK("busy_pulse_not_latched", a_busy, 1'b0)

        // Reset at round 5 discards the block
        a_in_data = CT1;
        a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        tick; tick; tick; tick;
        `CHK("midrst_rk_idx", a_rk_idx, 4'd5)
        rst = 1'b1;
        #1;
        `CHK("midrst_busy", a_busy, 1'b0)
        `CHK("midrst_in_ready", a_in_ready, 1'b0)
        tick;
        rst = 1'b0;
        ov_seen = 0;
        tick;
        `CHK("midrst_post_in_ready", a_in_ready, 1'b1)
        for (int i = 0; i < 12; i++) begin
            if (a_out_valid) ov_seen++;
            tick;
        end
        `CHK("midrst_no_out_valid", ov_seen, 0)
        run_a(CT1, pt, lat);
        `CHK("midrst_next_plaintext", pt, PT)
        `CHK("midrst_next_latency", lat, 10)
        tick;

        // NR=14, FIPS-197 C.3
        b_out_ready = 1'b1;
        b_in_data = CT3;
        b_in_valid = 1'b1;
        tick;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 50) begin tick; lat++; end
        chk_wait("c3_wait", lat, 50);
        `CHK("c3_latency", lat, 14)
        `CHK("c3_plaintext", b_out_data, PT)
        tick;
        `CHK("c3_back_idle", b_in_ready, 1'b1)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
- Iterative AES inverse-cipher engine: one 128-bit state register plus a round sequencer.
- Applies one decryption round per clock, in FIPS-197 inverse-cipher order, using the existing INV_Shift_Rows, INV_Sub_Bytes, INV_Mix_Columns and AddRoundKey XOR.
- Sits between the block-input FIFO and the plaintext output. Round keys come from the external key-schedule RAM, addressed by round index.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256).
- RW, $clog2(NR+1), round-counter and key-index width (derived; do not override).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  ciphertext block available
- in_ready  output  1  engine can accept a block
- in_data  input  128  ciphertext, byte 0 at [127:120]
- rk_idx  output  RW  round-key index requested this cycle
- rk_data  input  128  round key w[rk_idx], combinational from key RAM, same cycle
- out_valid  output  1  plaintext valid
- out_ready  input  1  downstream accepts plaintext
- out_data  output  128  plaintext, same byte order as in_data
- busy  output  1  high in ROUND or DONE

Behaviour:
- Reset: clk and rst as named above. rst is synchronous and active-high. On reset, FSM goes to IDLE, round counter = 0, state register = 0, out_valid = 0.
- Outputs during and after reset:
  - in_ready = 0 and busy = 0 while rst is high.
  - First cycle after rst deasserts: in_ready = 1.
  - rk_idx = NR while in IDLE.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1 and rk_idx = NR.
  - On in_valid & in_ready: state <= in_data ^ rk_data, cnt <= NR-1, go to ROUND.
- ROUND:
  - in_ready = 0 and rk_idx = cnt.
  - Let t = InvSubBytes(InvShiftRows(state)) ^ rk_data.
  - If cnt != 0: state <= InvMixColumns(t), cnt <= cnt-1.
  - If cnt == 0: state <= t (no InvMixColumns), go to DONE.
- DONE:
  - out_valid = 1, out_data = state. rk_idx = 0 (don't-care to the key RAM).
  - out_data is held stable while out_valid & !out_ready.
  - On out_ready: go to IDLE. in_ready is not asserted in the same cycle, so there is no DONE->ROUND bypass.
- Latency and throughput:
  - Accept edge is T0. Round edges are T1..TNR.
  - out_valid is high in the cycle after TNR, i.e. NR cycles after acceptance.
  - Peak throughput: one block per NR+2 cycles.
- Datapath rules:
  - All XORs are 128-bit bitwise; no carries.
  - cnt decrements and never wraps; the cnt==0 test precedes any decrement.
- Boundary conditions:
  - in_valid while busy: ignored, because in_ready = 0. The upstream must hold the block.
  - rst mid-round or in DONE: the block is discarded and out_valid drops on the next edge. No partial plaintext is ever emitted.
  - rk_data changing while in IDLE without acceptance: no effect.
  - out_ready high before out_valid: no effect.
- out_data is registered. rk_idx, in_ready and busy decode combinationally from FSM and cnt only, never from in_valid, so there is no combinational path from input to output.

Decomposition:
- Shared package aes_pkg holds:
  - typedef state_t (logic [127:0])
  - typedef byte_t
  - enum inv_fsm_t {IDLE, ROUND, DONE}
  - constants NR_128 = 10, NR_192 = 12, NR_256 = 14
- Sub-module aes_inv_round (combinational): inputs state, rk, last; output next_state.
  - Chains INV_Shift_Rows -> INV_Sub_Bytes -> AddRoundKey -> INV_Mix_Columns.
  - last = 1 bypasses InvMixColumns.
- The controller instantiates aes_inv_round once.

Test Plan:
- FIPS-197 C.1 (NR=10):
  - Key RAM loaded with the expansion of key 000102030405060708090a0b0c0d0e0f.
  - in_data = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_data = 00112233445566778899aabbccddeeff, with out_valid exactly 10 cycles after acceptance.
  - Required: rk_idx sequence 10,9,...,0.
- Backpressure:
  - Same vector, out_ready held 0 for 5 cycles after out_valid.
  - Required: out_data stable and out_valid high throughout; IDLE and in_ready = 1 one cycle after out_ready.
- Back-to-back:
  - Two blocks: C.1 ciphertext, then the C.1 ciphertext with byte 15 flipped, with in_valid continuously high.
  - Required: second acceptance exactly NR+2 cycles after the first; first plaintext correct; in_ready = 0 throughout ROUND.
- Reset mid-operation:
  - Assert rst at round 5 for 1 cycle.
  - Required: out_valid never asserts for that block; in_ready = 1 the cycle after rst deasserts; next block decrypts correctly.
- NR=14:
  - FIPS-197 C.3, key 000102...1f, in_data = 8ea2b7ca516745bfeafc49904b496089.
  - Required: out_data = 00112233445566778899aabbccddeeff after 14 cycles.
- Input while busy:
  - Pulse in_valid with a different block during ROUND.
  - Required: the pulse is ignored and the result equals the C.1 plaintext.
